aes128_state_collector: RTL and testbench
=========================================

// Module: aes128_state_collector
// PURPOSE
//  Sink end of the AES byte-stream interface driven by the sub-bytes stage.
//  Captures {data, addr, valid, done} byte writes into a 16-byte state register.
//  Tracks per-byte fill status and presents the completed state with a
//  valid/consume handshake to the next round stage (shift-rows/mix-columns).
// PARAMETERS
//  N_BYTES   16   number of state bytes; addr_i range 0..N_BYTES-1
// PORTS
//  clk_i          in   1           clock, all logic on posedge
//  rst_i          in   1           synchronous, active-high reset
//  clear_i        in   1           abort capture, return to IDLE
//  data_i         in   8           byte value from the upstream stage
//  addr_i         in   4           byte index for data_i
//  valid_i        in   1           data_i/addr_i valid this cycle
//  done_i         in   1           upstream end-of-stream pulse
//  consume_i      in   1           downstream takes state_o (only meaningful in FULL)
//  state_o        out  N_BYTES*8   collected state; byte k at state_o[k]
//  state_valid_o  out  1           state_o complete and held
//  byte_mask_o    out  N_BYTES     bit k = byte k written in current capture
//  busy_o         out  1           capture in progress (state COLLECT)
//  err_o          out  1           sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state_o=0, byte_mask_o=0, state_valid_o=0, busy_o=0, err_o=0, state IDLE.
//  FSM: IDLE -> COLLECT -> FULL -> IDLE.
//  Priority each cycle: rst_i > clear_i > consume_i > valid_i > done_i.
//  IDLE: valid_i with addr_i<N_BYTES writes byte, sets mask bit -> COLLECT.
//   If N_BYTES==1, that write goes straight to FULL.
//  COLLECT: valid_i writes state_o[addr_i]<=data_i, mask[addr_i]<=1.
//   When mask incl. this write is all-ones -> FULL next cycle.
//   Duplicate addr: data overwritten, mask unchanged.
//   done_i with mask incomplete (after this cycle's write): mask cleared -> IDLE.
//  FULL: state_valid_o=1, state_o frozen; valid_i dropped; done_i ignored.
//   consume_i: mask cleared -> IDLE; state_o contents retained.
//   consume_i & valid_i same cycle: new byte accepted as first byte of next
//   capture -> COLLECT (mask = only that bit).
//  addr_i >= N_BYTES: write ignored in every state.
//  Latency: written byte visible on state_o/byte_mask_o the cycle after valid_i;
//   state_valid_o rises the cycle after the completing write. 16 back-to-back
//   writes starting cycle 0 -> state_valid_o high at cycle 16.
//  clear_i: mask=0, err_o=0, -> IDLE; state_o unchanged; same-cycle valid_i dropped.
//  busy_o = (state==COLLECT); state_valid_o = (state==FULL); both registered.
// CONFIGURATION
//  AES128_COLLECT_ERR_EN defined: err_o set (sticky until clear_i/rst_i) on
//   duplicate addr in COLLECT, valid_i dropped in FULL, addr_i>=N_BYTES,
//   or done_i with incomplete mask. err_o rises the cycle after the event.
//  Undefined: no error logic synthesised; err_o tied 0; data behaviour identical.
// TESTING
//  Reset: rst_i=1 one cycle -> all outputs 0, state IDLE.
//  Stream addr 0..15, data=addr^8'h63, 16 consecutive cycles -> state_valid_o
//   at cycle 16, state_o[k]=k^8'h63, byte_mask_o=16'hFFFF; done_i ignored.
//  Out-of-order addrs 15..0 with 2-cycle gaps -> same final state, busy_o high
//   until FULL; consume_i -> IDLE next cycle, state_o retained.
//  In FULL: consume_i & valid_i(addr 3, 8'hAA) same cycle -> COLLECT,
//   byte_mask_o=16'h0008, state_o[3]=8'hAA.
//  8 bytes then done_i -> IDLE, mask 0; with ERR_EN err_o=1 until clear_i.
//  Duplicate addr 5 (8'h11 then 8'h22) -> state_o[5]=8'h22, mask bit 5 once;
//   with ERR_EN err_o=1; without, err_o=0.

Source files
------------

// File: rtl/aes128_state_collector_if.sv
// Byte-stream bus between the sub-bytes stage (master) and the state collector (slave).
interface aes128_state_collector_if #(
    parameter int N_BYTES = 16
);
    logic                   clear_i;
    logic [7:0]             data_i;
    logic [3:0]             addr_i;
    logic                   valid_i;
    logic                   done_i;
    logic                   consume_i;
    logic [N_BYTES*8-1:0]   state_o;
    logic                   state_valid_o;
    logic [N_BYTES-1:0]     byte_mask_o;
    logic                   busy_o;
    logic                   err_o;

    modport master (
        output clear_i, data_i, addr_i, valid_i, done_i, consume_i,
        input  state_o, state_valid_o, byte_mask_o, busy_o, err_o
    );

    modport slave (
        input  clear_i, data_i, addr_i, valid_i, done_i, consume_i,
        output state_o, state_valid_o, byte_mask_o, busy_o, err_o
    );
endinterface

// File: rtl/aes128_state_collector.sv
// Collects AES byte writes into a 16-byte state and hands it on with a valid/consume handshake.
// Define AES128_COLLECT_ERR_EN to build the sticky protocol-error flag (err_o tied 0 otherwise).
module aes128_state_collector #(
    parameter int N_BYTES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    aes128_state_collector_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } state_t;

    state_t               state_q, state_n;
    logic [N_BYTES-1:0]   mask_q, mask_n, mask_w, addr_bit;
    logic [N_BYTES*8-1:0] data_q;
    logic                 busy_q, valid_q;
    logic                 in_range, hit, wr_en;

    always_comb begin
        in_range = ({28'd0, bus.addr_i} < 32'(N_BYTES));
        hit      = bus.valid_i && in_range;
        addr_bit = '0;
        if (in_range)
            addr_bit[bus.addr_i] = 1'b1;
        mask_w   = mask_q | (hit ? addr_bit : '0);

        state_n  = state_q;
        mask_n   = mask_q;
        wr_en    = 1'b0;

        if (bus.clear_i) begin
            state_n = IDLE;
            mask_n  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hit) begin
                        wr_en   = 1'b1;
                        mask_n  = addr_bit;
                        state_n = (&addr_bit) ? FULL : COLLECT;
                    end
                end
                COLLECT: begin
                    wr_en  = hit;
                    mask_n = mask_w;
                    // A completing write wins over a same-cycle done_i.
                    if (&mask_w) begin
                        state_n = FULL;
                    end else if (bus.done_i) begin
                        mask_n  = '0;
                        state_n = IDLE;
                    end
                end
                FULL: begin
                    if (bus.consume_i) begin
                        wr_en   = hit;
                        mask_n  = hit ? addr_bit : '0;
                        state_n = hit ? ((&addr_bit) ? FULL : COLLECT) : IDLE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    mask_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            mask_q  <= '0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_n;
            mask_q  <= mask_n;
            busy_q  <= (state_n == COLLECT);
            valid_q <= (state_n == FULL);
            if (wr_en)
                data_q[{bus.addr_i, 3'b000} +: 8] <= bus.data_i;
        end
    end

`ifdef AES128_COLLECT_ERR_EN
    logic err_q, err_evt;

    always_comb begin
        err_evt = 1'b0;
        if (!bus.clear_i) begin
            if (bus.valid_i && !in_range)
                err_evt = 1'b1;
            if (state_q == COLLECT && hit && (|(mask_q & addr_bit)))
                err_evt = 1'b1;
            if (state_q == COLLECT && bus.done_i && !(&mask_w))
                err_evt = 1'b1;
            if (state_q == FULL && !bus.consume_i && bus.valid_i)
                err_evt = 1'b1;
        end
    end

    // Sticky until clear_i or reset.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            err_q <= 1'b0;
        else if (bus.clear_i)
            err_q <= 1'b0;
        else if (err_evt)
            err_q <= 1'b1;
    end

    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif

    assign bus.state_o       = data_q;
    assign bus.byte_mask_o   = mask_q;
    assign bus.busy_o        = busy_q;
    assign bus.state_valid_o = valid_q;
endmodule

// File: tb/tb_aes128_state_collector.sv
// Directed self-checking bench for aes128_state_collector; honours AES128_COLLECT_ERR_EN.
module tb_aes128_state_collector;
`ifdef AES128_COLLECT_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [127:0] exp_state = '0;

    aes128_state_collector_if #(.N_BYTES(16)) dut_if ();

    aes128_state_collector #(.N_BYTES(16)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (dut_if)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] addr, input logic [7:0] data,
                                 input logic done, input logic consume, input logic clear);
        dut_if.valid_i   = valid;
        dut_if.addr_i    = addr;
        dut_if.data_i    = data;
        dut_if.done_i    = done;
        dut_if.consume_i = consume;
        dut_if.clear_i   = clear;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        dut_if.valid_i   = 1'b0;
        dut_if.addr_i    = '0;
        dut_if.data_i    = '0;
        dut_if.done_i    = 1'b0;
        dut_if.consume_i = 1'b0;
        dut_if.clear_i   = 1'b0;

        // Reset
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checkOutput("rst_state",  dut_if.state_o, '0);
        checkOutput("rst_mask",   128'(dut_if.byte_mask_o), 128'h0);
        checkOutput("rst_valid",  128'(dut_if.state_valid_o), 128'h0);
        checkOutput("rst_busy",   128'(dut_if.busy_o), 128'h0);
        checkOutput("rst_err",    128'(dut_if.err_o), 128'h0);

        // In-order stream, one byte per cycle
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 4'(k), 8'(k) ^ 8'h63, 1'b0, 1'b0, 1'b0);
            exp_state[k*8 +: 8] = 8'(k) ^ 8'h63;
            if (k == 0) begin
                checkOutput("seq_first_mask", 128'(dut_if.byte_mask_o), 128'h0001);
                checkOutput("seq_first_busy", 128'(dut_if.busy_o), 128'h1);
                checkOutput("seq_first_byte", 128'(dut_if.state_o[7:0]), 128'h63);
            end
            if (k == 14)
                checkOutput("seq_valid_c15", 128'(dut_if.state_valid_o), 128'h0);
        end
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOutput("seq_valid_c16", 128'(dut_if.state_valid_o), 128'h1);
        checkOutput("seq_mask",      128'(dut_if.byte_mask_o), 128'hFFFF);
        checkOutput("seq_state",     dut_if.state_o, exp_state);
        checkOutput("seq_busy",      128'(dut_if.busy_o), 128'h0);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("full_done_valid", 128'(dut_if.state_valid_o), 128'h1);
        checkOutput("full_done_mask",  128'(dut_if.byte_mask_o), 128'hFFFF);
        checkOutput("full_done_err",   128'(dut_if.err_o), 128'h0);

        // consume with a same-cycle write starts the next capture
        applyStimulus(1'b1, 4'd3, 8'hAA, 1'b0, 1'b1, 1'b0);
        exp_state[3*8 +: 8] = 8'hAA;
        checkOutput("cv_busy",  128'(dut_if.busy_o), 128'h1);
        checkOutput("cv_valid", 128'(dut_if.state_valid_o), 128'h0);
        checkOutput("cv_mask",  128'(dut_if.byte_mask_o), 128'h0008);
        checkOutput("cv_state", dut_if.state_o, exp_state);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_mask",  128'(dut_if.byte_mask_o), 128'h0);
        checkOutput("clr_busy",  128'(dut_if.busy_o), 128'h0);
        checkOutput("clr_state", dut_if.state_o, exp_state);

        // Reverse order with two idle cycles between writes
        for (int k = 15; k >= 0; k--) begin
            applyStimulus(1'b1, 4'(k), 8'(k) ^ 8'h63, 1'b0, 1'b0, 1'b0);
            exp_state[k*8 +: 8] = 8'(k) ^ 8'h63;
            applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
            applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0);
            if (k == 1) begin
                checkOutput("rev_busy_gap", 128'(dut_if.busy_o), 128'h1);
                checkOutput("rev_mask_gap", 128'(dut_if.byte_mask_o), 128'hFFFE);
            end
        end
        checkOutput("rev_valid", 128'(dut_if.state_valid_o), 128'h1);
        checkOutput("rev_busy",  128'(dut_if.busy_o), 128'h0);
        checkOutput("rev_state", dut_if.state_o, exp_state);

        // Write while FULL without consume is dropped
        applyStimulus(1'b1, 4'd0, 8'hEE, 1'b0, 1'b0, 1'b0);
        checkOutput("drop_state", dut_if.state_o, exp_state);
        checkOutput("drop_valid", 128'(dut_if.state_valid_o), 128'h1);
        checkOutput("drop_err",   128'(dut_if.err_o), 128'(ERR_EN));
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("cons_valid", 128'(dut_if.state_valid_o), 128'h0);
        checkOutput("cons_busy",  128'(dut_if.busy_o), 128'h0);
        checkOutput("cons_mask",  128'(dut_if.byte_mask_o), 128'h0);
        checkOutput("cons_state", dut_if.state_o, exp_state);

        // Early done after eight bytes
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 4'(k), 8'hF0 + 8'(k), 1'b0, 1'b0, 1'b0);
            exp_state[k*8 +: 8] = 8'hF0 + 8'(k);
        end
        checkOutput("part_mask", 128'(dut_if.byte_mask_o), 128'h00FF);
        checkOutput("part_busy", 128'(dut_if.busy_o), 128'h1);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOutput("done_busy",  128'(dut_if.busy_o), 128'h0);
        checkOutput("done_mask",  128'(dut_if.byte_mask_o), 128'h0);
        checkOutput("done_valid", 128'(dut_if.state_valid_o), 128'h0);
        checkOutput("done_err",   128'(dut_if.err_o), 128'(ERR_EN));
        checkOutput("done_state", dut_if.state_o, exp_state);
        applyStimulus(1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("done_clr_err", 128'(dut_if.err_o), 128'h0);

        // Duplicate address overwrites data, mask unchanged
        applyStimulus(1'b1, 4'd5, 8'h11, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'd5, 8'h22, 1'b0, 1'b0, 1'b0);
        exp_state[5*8 +: 8] = 8'h22;
        checkOutput("dup_state", dut_if.state_o, exp_state);
        checkOutput("dup_mask",  128'(dut_if.byte_mask_o), 128'h0020);
        checkOutput("dup_busy",  128'(dut_if.busy_o), 128'h1);
        checkOutput("dup_err",   128'(dut_if.err_o), 128'(ERR_EN));

        // clear drops a same-cycle write
        applyStimulus(1'b1, 4'd9, 8'h77, 1'b0, 1'b0, 1'b1);
        checkOutput("clrw_state", dut_if.state_o, exp_state);
        checkOutput("clrw_mask",  128'(dut_if.byte_mask_o), 128'h0);
        checkOutput("clrw_busy",  128'(dut_if.busy_o), 128'h0);
        checkOutput("clrw_err",   128'(dut_if.err_o), 128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
